// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam int         MULDIV_XLEN   = 32;
    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    // funct3 encodings of the M-extension ops
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 datapath: shift-add multiply / restoring shift-subtract divide on magnitudes.
// Latency: one step per step_i cycle; XLEN steps give the full product or quotient/remainder.
// Backpressure: none; the controlling FSM sequences load_i/step_i.
// Ports: clk, rstn; load_i (capture operands, clear accumulator), step_i (one iteration),
//        is_div_i (divide vs multiply at load), a_i/b_i (unsigned magnitudes),
//        hi_o (product high / remainder), lo_o (product low / quotient).
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    // acc_q: product high half / partial remainder
    // lo_q : multiplier being shifted out (mul) or dividend shifted out / quotient shifted in (div)
    // m_q  : multiplicand (mul) or divisor (div)
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] m_q;
    logic            is_div_q;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_ge;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_shift = {acc_q, lo_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, m_q});
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q    <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            is_div_q <= 1'b0;
        end else if (load_i) begin
            acc_q    <= '0;
            is_div_q <= is_div_i;
            lo_q     <= is_div_i ? a_i : b_i;
            m_q      <= is_div_i ? b_i : a_i;
        end else if (step_i) begin
            if (is_div_q) begin
                // Remainder stays below the divisor, so the difference fits in XLEN bits.
                acc_q <= div_ge ? (div_shift[XLEN-1:0] - m_q) : div_shift[XLEN-1:0];
                lo_q  <= {lo_q[XLEN-2:0], div_ge};
            end else begin
                acc_q <= mul_sum[XLEN:1];
                lo_q  <= {mul_sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    assign hi_o = acc_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative RV32M multiply/divide with sign handling and special-case shortcuts.
// Latency: done_o XLEN+2 cycles after accept; div-by-zero/overflow (and multiplies when
//          MULDIV_FAST_MUL_EN is defined) finish in 1 cycle.
// Backpressure: stall_o (combinational) holds the pipeline until the done_o cycle; flush_i aborts.
// Ports: clk, rstn, start_i, flush_i, funct3_i, rs1_i, rs2_i, rd_i -> stall_o, done_o, result_o, rd_o.
// Optional macro: MULDIV_FAST_MUL_EN selects a single-cycle multiplier for MUL/MULH/MULHSU/MULHU.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam int CW = $clog2(XLEN);

    muldiv_state_e   state_q, state_d;
    muldiv_op_e      op_q;
    logic [4:0]      rd_q;
    logic            sign_a_q, sign_b_q;
    logic [CW-1:0]   cnt_q;

    // ---------------- input decode ----------------
    muldiv_op_e      op_in;
    logic            in_div;
    logic            a_signed, b_signed;
    logic            neg_a, neg_b;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf, fast_op;
    logic [XLEN-1:0] spec_res, short_res;
    logic            accept, short_path;

    always_comb begin
        op_in    = muldiv_op_e'(funct3_i);
        in_div   = funct3_i[2];
        // MULHSU treats only rs1 as signed; the unsigned forms treat neither.
        a_signed = (op_in == MUL) || (op_in == MULH) || (op_in == MULHSU) ||
                   (op_in == DIV) || (op_in == REM);
        b_signed = (op_in == MUL) || (op_in == MULH) || (op_in == DIV) || (op_in == REM);
        neg_a    = a_signed & rs1_i[XLEN-1];
        neg_b    = b_signed & rs2_i[XLEN-1];
        abs_a    = neg_a ? -rs1_i : rs1_i;
        abs_b    = neg_b ? -rs2_i : rs2_i;

        div_zero = in_div && (rs2_i == '0);
        div_ovf  = ((op_in == DIV) || (op_in == REM)) &&
                   (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
        // funct3[1] distinguishes REM* from DIV*. On overflow the quotient equals rs1.
        if (div_zero)
            spec_res = funct3_i[1] ? rs1_i : '1;
        else
            spec_res = funct3_i[1] ? '0 : rs1_i;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_prod;
    always_comb begin
        fast_op   = !in_div;
        // Sign-extend to XLEN+1 so one signed multiplier covers all four multiply flavours.
        fast_a    = {a_signed & rs1_i[XLEN-1], rs1_i};
        fast_b    = {b_signed & rs2_i[XLEN-1], rs2_i};
        fast_prod = fast_a * fast_b;
        short_res = fast_op ? ((op_in == MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN])
                            : spec_res;
    end
`else
    always_comb begin
        fast_op   = 1'b0;
        short_res = spec_res;
    end
`endif

    assign short_path = div_zero || div_ovf || fast_op;
    assign accept     = (state_q == IDLE) && start_i && !flush_i;

    // ---------------- iterative core ----------------
    logic            core_load, core_step;
    logic [XLEN-1:0] core_hi, core_lo;

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .rstn     (rstn),
        .load_i   (core_load),
        .step_i   (core_step),
        .is_div_i (in_div),
        .a_i      (abs_a),
        .b_i      (abs_b),
        .hi_o     (core_hi),
        .lo_o     (core_lo)
    );

    // ---------------- sign fix-up ----------------
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, fix_res;

    always_comb begin
        prod_s = (sign_a_q ^ sign_b_q) ? -{core_hi, core_lo} : {core_hi, core_lo};
        quot_s = (sign_a_q ^ sign_b_q) ? -core_lo : core_lo;
        rem_s  = sign_a_q ? -core_hi : core_hi;
        case (op_q)
            MUL:                 fix_res = prod_s[XLEN-1:0];
            MULH, MULHSU, MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
            DIV, DIVU:           fix_res = quot_s;
            default:             fix_res = rem_s;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        stall_o   = 1'b0;
        done_o    = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    stall_o = 1'b1;
                    if (short_path) begin
                        state_d = DONE;
                    end else begin
                        core_load = 1'b1;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                stall_o   = 1'b1;
                core_step = 1'b1;
                if (cnt_q == CW'(XLEN-1)) state_d = FIX;
            end
            FIX: begin
                stall_o = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A flush overrides everything: nothing is accepted, stepped or reported.
        if (flush_i) begin
            state_d   = IDLE;
            stall_o   = 1'b0;
            done_o    = 1'b0;
            core_load = 1'b0;
            core_step = 1'b0;
        end
    end

    // ---------------- control/result registers ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q     <= MUL;
            rd_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            if (accept) begin
                op_q     <= op_in;
                rd_q     <= rd_i;
                sign_a_q <= neg_a;
                sign_b_q <= neg_b;
                cnt_q    <= '0;
            end else if (core_step) begin
                cnt_q <= cnt_q + CW'(1);
            end

            if (accept && short_path) begin
                result_o <= short_res;
                rd_o     <= rd_i;
            end else if ((state_q == FIX) && !flush_i) begin
                result_o <= fix_res;
                rd_o     <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed ops push expected result/rd/due-cycle,
// a negedge monitor pops and compares on every done_o.
module tb_ex_muldiv_unit;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011,
                           F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i;
    logic [4:0]  rd_i;
    logic        stall_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    ex_muldiv_unit dut (
        .clk      (clk),
        .rstn     (rstn),
        .start_i  (start_i),
        .flush_i  (flush_i),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .rd_i     (rd_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done_o must match the oldest expectation.
    always @(negedge clk) begin
        if (rstn && done_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: rd_o=%0d result_o=0x%08h with nothing pending", rd_o, result_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", result_o, e.res);
                chk("rd", 32'(rd_o), 32'(e.rd));
                chk("latency", cyc, e.due);
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 of the cycle after done_o.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat);
        int scnt;
        int budget;
        start_i  = 1'b1;
        funct3_i = f;
        rs1_i    = a;
        rs2_i    = b;
        rd_i     = rd;
        sb_q.push_back('{exp, rd, cyc + lat});
        scnt   = 0;
        budget = 0;
        while (sb_q.size() != 0 && budget < 100) begin
            @(negedge clk);
            if (stall_o) scnt++;
            @(posedge clk);
            #1;
            start_i = 1'b0;
            budget++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done_o for funct3=%0d within %0d cycles", f, budget);
            sb_q.delete();
        end
        chk("stall_cycles", scnt, lat);
    endtask

    initial begin
        rstn = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        funct3_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(done_o), 0);
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_result", result_o, 0);
        chk("rst_rd", 32'(rd_o), 0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;

        // Normal divides and special cases
        run_op(F_DIV,  32'd20,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFFA, 34);
        run_op(F_REM,  32'd20,        32'hFFFFFFFD, 5'd2,  32'h00000002, 34);
        run_op(F_DIVU, 32'd7,         32'd0,        5'd3,  32'hFFFFFFFF, 1);
        run_op(F_REMU, 32'd7,         32'd0,        5'd4,  32'h00000007, 1);
        run_op(F_DIV,  32'h80000000,  32'hFFFFFFFF, 5'd5,  32'h80000000, 1);
        run_op(F_REM,  32'h80000000,  32'hFFFFFFFF, 5'd6,  32'h00000000, 1);
        run_op(F_DIV,  32'hFFFFFFF9,  32'd2,        5'd7,  32'hFFFFFFFD, 34);
        run_op(F_REM,  32'hFFFFFFF9,  32'd2,        5'd8,  32'hFFFFFFFF, 34);
        run_op(F_DIVU, 32'hFFFFFFFF,  32'd16,       5'd9,  32'h0FFFFFFF, 34);
        run_op(F_REMU, 32'hFFFFFFFF,  32'd16,       5'd10, 32'h0000000F, 34);
        run_op(F_DIV,  32'h80000000,  32'd1,        5'd11, 32'h80000000, 34);
        run_op(F_REM,  32'hFFFFFFF9,  32'd0,        5'd12, 32'hFFFFFFF9, 1);

        // Multiplies
        run_op(F_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'h00000000, MUL_LAT);
        run_op(F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'hFFFFFFFE, MUL_LAT);
        run_op(F_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 32'h00000001, MUL_LAT);
        run_op(F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd16, 32'hFFFFFFFF, MUL_LAT);
        run_op(F_MUL,    32'h12345678, 32'h00000010, 5'd17, 32'h23456780, MUL_LAT);
        run_op(F_MULH,   32'h80000000, 32'h80000000, 5'd18, 32'h40000000, MUL_LAT);

        // Flush a divide at cycle 10; nothing may be reported for it.
        start_i = 1'b1; funct3_i = F_DIV; rs1_i = 32'd100; rs2_i = 32'd7; rd_i = 5'd20;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("stall_before_flush", 32'(stall_o), 1);
        flush_i = 1'b1;
        #1;
        chk("flush_stall_drop", 32'(stall_o), 0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("idle_after_flush", 32'(stall_o), 0);
        run_op(F_DIV, 32'd100, 32'd7, 5'd21, 32'd14, 34);

        // start together with flush must not be accepted
        start_i = 1'b1; flush_i = 1'b1; funct3_i = F_DIV; rs1_i = 32'd9; rs2_i = 32'd3; rd_i = 5'd22;
        #1;
        chk("flush_start_stall", 32'(stall_o), 0);
        @(posedge clk);
        #1;
        start_i = 1'b0; flush_i = 1'b0;
        chk("flush_start_not_taken", 32'(stall_o), 0);
        repeat (40) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a divide
        start_i = 1'b1; funct3_i = F_DIV; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd23;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("stall_before_reset", 32'(stall_o), 1);
        rstn = 1'b0;
        #1;
        chk("arst_stall", 32'(stall_o), 0);
        chk("arst_done", 32'(done_o), 0);
        chk("arst_result", result_o, 0);
        chk("arst_rd", 32'(rd_o), 0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;
        run_op(F_DIV, 32'd1000, 32'd3, 5'd24, 32'd333, 34);

        repeat (5) @(posedge clk);
        #1;
        chk("pending_at_end", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
